// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-end and timekeeping stages.
// Holds field indices, the select width, key bit positions, the adjust-mode
// state type and a field-advance helper.
package clock_pkg;

  localparam int SELECT_W = 4;
  localparam int NUM_KEYS = 4;

  // Adjustable field indices, in select order
  localparam logic [SELECT_W-1:0] FIELD_SEC    = 4'd0;
  localparam logic [SELECT_W-1:0] FIELD_MIN    = 4'd1;
  localparam logic [SELECT_W-1:0] FIELD_HOUR   = 4'd2;
  localparam logic [SELECT_W-1:0] FIELD_DAY    = 4'd3;
  localparam logic [SELECT_W-1:0] FIELD_MONTH  = 4'd4;
  localparam logic [SELECT_W-1:0] FIELD_YEAR_L = 4'd5;
  localparam logic [SELECT_W-1:0] FIELD_YEAR_H = 4'd6;

  // Bit positions inside KEY[3:0]
  localparam int KEY_ADD  = 0;
  localparam int KEY_CLR  = 1;
  localparam int KEY_NEXT = 2;
  localparam int KEY_ADJ  = 3;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_ADJ = 1'b1
  } mode_e;

  // Advance a field index, wrapping after the last field.
  function automatic logic [SELECT_W-1:0] next_field(
    input logic [SELECT_W-1:0] cur,
    input logic [SELECT_W-1:0] last
  );
    return (cur >= last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser + debouncer.
//   CLOCK_50 : clock, rising edge
//   rst      : synchronous active-high reset
//   key_n    : raw asynchronous active-low button
//   level    : debounced level (1 = released)
//   press    : one-cycle pulse on a debounced 1->0 transition
// A key that is still down when reset is released is not reported until it
// has been seen released at least once (arm_q).
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fill_q;
  logic             arm_q, arm_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // sync2_q only reflects the real key once fill_q[1] is set; before that
    // it still shows the reset value and must not arm the key.
    arm_d = arm_q | (fill_q[1] & sync2_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fill_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fill_q  <= {fill_q[0], 1'b1};
      arm_q   <= arm_d;
    end
  end

  assign level = level_q;
  assign press = arm_q & level_q & ~level_d;

endmodule

// File: rtl/key_control.sv
// Push-button front end for the clock: debounces KEY[3:0] and turns presses
// into add/clr pulses, the adjust-mode level and the field select index.
//   CLOCK_50 : clock, rising edge
//   rst      : synchronous active-high reset
//   KEY      : raw active-low buttons (0 add, 1 clr, 2 next field, 3 adjust)
//   add      : one-cycle increment pulse (adjust mode only)
//   clr      : one-cycle clear pulse
//   adjust   : 1 = adjust mode
//   select   : field being adjusted, 0..NUM_FIELDS-1
// Optional: define KEY_AUTO_REPEAT_EN to auto-repeat add while KEY[0] is held.
module key_control
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_FIELDS      = 7,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic [3:0]          KEY,
  output logic                add,
  output logic                clr,
  output logic                adjust,
  output logic [SELECT_W-1:0] select
);

  localparam logic [SELECT_W-1:0] LAST_FIELD = SELECT_W'(NUM_FIELDS - 1);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  genvar k;
  generate
    for (k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .key_n   (KEY[k]),
        .level   (key_level[k]),
        .press   (key_press[k])
      );
    end
  endgenerate

  mode_e               mode_q, mode_d;
  logic [SELECT_W-1:0] sel_q, sel_d;
  logic                add_q, add_d;
  logic                clr_q, clr_d;
  logic                rpt_fire;

`ifdef KEY_AUTO_REPEAT_EN
  // rpt_q counts cycles since the accepted add press while the key stays
  // down; 0 means idle. After a fire it is rewound so the next fire lands
  // REPEAT_PERIOD cycles later.
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_REWIND = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (mode_q == MODE_ADJ) begin
      if (key_press[KEY_ADD]) begin
        rpt_d = RPT_W'(1);
      end else if ((rpt_q != '0) && !key_level[KEY_ADD]) begin
        if (rpt_q == RPT_FIRE) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_REWIND;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Mode/select FSM. KEY[3] wins over KEY[2] when both land together.
  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    add_d  = (key_press[KEY_ADD] & (mode_q == MODE_ADJ)) | rpt_fire;
    clr_d  = key_press[KEY_CLR];
    case (mode_q)
      MODE_RUN: begin
        if (key_press[KEY_ADJ]) begin
          mode_d = MODE_ADJ;
          sel_d  = '0;
        end
      end
      MODE_ADJ: begin
        if (key_press[KEY_ADJ]) mode_d = MODE_RUN;
        else if (key_press[KEY_NEXT]) sel_d = next_field(sel_q, LAST_FIELD);
      end
      default: mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      mode_q <= MODE_RUN;
      sel_q  <= '0;
      add_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      add_q  <= add_d;
      clr_q  <= clr_d;
    end
  end

  assign add    = add_q;
  assign clr    = clr_q;
  assign adjust = (mode_q == MODE_ADJ);
  assign select = sel_q;

endmodule

// File: tb/tb_key_control.sv
`timescale 1ns/1ps
module tb_key_control;

  localparam int D  = 8;
  localparam int NF = 7;
  localparam int RD = 40;
  localparam int RP = 10;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [3:0] KEY;
  logic       add, clr, adjust;
  logic [3:0] select;

  key_control #(
    .DEBOUNCE_CYCLES(D), .NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .KEY(KEY),
    .add(add), .clr(clr), .adjust(adjust), .select(select)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Sync value of a key = raw KEY two edges ago. A debounced level flips
  // after D consecutive cycles of disagreement. Keys seen down right after
  // reset stay silent until observed up.
  bit [3:0] m_s1, m_s2, m_lvl, m_arm;
  int       m_run [4];
  int       m_since;
  bit       m_add, m_clr, m_adj;
  int       m_sel;
  bit       m_rpt_on;
  int       m_rpt_age;

  always @(posedge CLOCK_50) begin
    bit ev [4];
    bit adj_old, lvl0_old;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_arm = 4'h0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_since = 0; m_add = 0; m_clr = 0; m_adj = 0; m_sel = 0;
      m_rpt_on = 0; m_rpt_age = 0;
    end else begin
      adj_old  = m_adj;
      lvl0_old = m_lvl[0];
      for (int k = 0; k < 4; k++) begin
        ev[k] = 0;
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = m_s2[k];
            m_run[k] = 0;
            ev[k] = (m_lvl[k] == 0) && m_arm[k];
          end
        end else m_run[k] = 0;
        if (m_since >= 2 && m_s2[k]) m_arm[k] = 1;
        m_s2[k] = m_s1[k];
        m_s1[k] = KEY[k];
      end
      m_since++;
      m_add = ev[0] && adj_old;
      m_clr = ev[1];
      if (ev[3]) begin
        m_adj = !m_adj;
        if (m_adj) m_sel = 0;
      end else if (ev[2] && adj_old) m_sel = (m_sel + 1) % NF;
`ifdef KEY_AUTO_REPEAT_EN
      if (!adj_old) m_rpt_on = 0;
      else if (ev[0]) begin m_rpt_on = 1; m_rpt_age = 0; end
      else if (m_rpt_on && !lvl0_old) begin
        m_rpt_age++;
        if (m_rpt_age >= RD && (m_rpt_age - RD) % RP == 0) m_add = 1;
      end else m_rpt_on = 0;
`endif
    end
  end

  // ---------------- per-cycle compare + pulse bookkeeping ----------------
  bit chk_en = 0;
  bit cap_en = 0;
  int cyc = 0;
  int add_cnt = 0, clr_cnt = 0;
  int add_t [$];

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("m_add", int'(add), int'(m_add));
      chk("m_clr", int'(clr), int'(m_clr));
      chk("m_adj", int'(adjust), int'(m_adj));
      chk("m_sel", int'(select), m_sel);
      if (add === 1'b1) add_cnt++;
      if (clr === 1'b1) clr_cnt++;
      if (cap_en && add === 1'b1) add_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    KEY = KEY & ~mask;
    tick(hold);
    KEY = KEY | mask;
    tick(gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, c0;
    int exp_off [$];
    rst = 1'b1;
    KEY = 4'hF;

    // 1. reset
    tick(1);
    chk_en = 1;
    chk("rst_add", int'(add), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_adj", int'(adjust), 0);
    chk("rst_sel", int'(select), 0);
    tick(2);
    rst = 1'b0;
    tick(5);

    // 2. bounce on clr key
    c0 = clr_cnt;
    KEY[1] = 0; tick(5);
    KEY[1] = 1; tick(2);
    KEY[1] = 0;
    tick(9);
    chk("bnc_early", int'(clr), 0);
    tick(1);
    chk("bnc_pulse", int'(clr), 1);
    tick(1);
    chk("bnc_one", int'(clr), 0);
    tick(20);
    KEY[1] = 1;
    tick(20);
    chk("bnc_cnt", clr_cnt - c0, 1);

    // 3. mode gating and select walk
    a0 = add_cnt;
    press(4'b0001, 15, 15);
    chk("gate_noadd", add_cnt - a0, 0);
    press(4'b1000, 15, 15);
    chk("ent_adj", int'(adjust), 1);
    chk("ent_sel", int'(select), 0);
    a0 = add_cnt;
    press(4'b0001, 15, 15);
    chk("adj_add", add_cnt - a0, 1);
    for (int i = 0; i < 7; i++) begin
      press(4'b0100, 15, 15);
      chk("sel_walk", int'(select), (i + 1) % NF);
    end

    // 4. simultaneous next + adjust
    for (int i = 0; i < 3; i++) press(4'b0100, 15, 15);
    chk("sim_pre", int'(select), 3);
    press(4'b1100, 15, 15);
    chk("sim_adj0", int'(adjust), 0);
    chk("sim_sel3", int'(select), 3);
    press(4'b1100, 15, 15);
    chk("sim_adj1", int'(adjust), 1);
    chk("sim_sel0", int'(select), 0);

    // 5. reset mid-hold
    for (int i = 0; i < 5; i++) press(4'b0100, 15, 15);
    chk("mid_sel5", int'(select), 5);
    a0 = add_cnt;
    KEY[0] = 0; tick(4);
    rst = 1; tick(1);
    rst = 0;
    tick(25);
    chk("mid_adj", int'(adjust), 0);
    chk("mid_sel", int'(select), 0);
    chk("mid_noadd", add_cnt - a0, 0);
    KEY[0] = 1; tick(15);
    press(4'b0001, 15, 15);
    chk("mid_run_noadd", add_cnt - a0, 0);
    press(4'b1000, 15, 15);
    press(4'b0001, 15, 15);
    chk("mid_readd", add_cnt - a0, 1);

    // 6. hold add in adjust mode
    add_t.delete();
    cap_en = 1;
    press(4'b0001, 95, 40);
    cap_en = 0;
    exp_off.push_back(0);
`ifdef KEY_AUTO_REPEAT_EN
    for (int i = 0; i < 6; i++) exp_off.push_back(RD + i * RP);
`endif
    chk("rpt_n", add_t.size(), exp_off.size());
    if (add_t.size() == exp_off.size())
      for (int i = 0; i < exp_off.size(); i++)
        chk("rpt_off", add_t[i] - add_t[0], exp_off[i]);

    // 7. random traffic against the model
    for (int e = 0; e < 60; e++) begin
      logic [3:0] m;
      int hold;
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, D - 1);
      else hold = $urandom_range(D + 1, 70);
      if ($urandom_range(0, 14) == 0) begin
        KEY = KEY & ~m; tick($urandom_range(1, 6));
        rst = 1; tick($urandom_range(1, 2)); rst = 0;
        tick(hold);
        KEY = 4'hF;
        tick($urandom_range(12, 30));
      end else begin
        press(m, hold, $urandom_range(12, 30));
      end
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_control.md
Name: key_control

Overview:
- Front-end stage between the DE2 push-buttons and the timekeeping core.
- Synchronises and debounces the four active-low KEY inputs.
- Produces single-cycle add/clr command pulses, an adjust-mode level, and a field-select index.
- These outputs drive the time counter and display stages.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); minimum 2.
- NUM_FIELDS, 7, number of adjustable fields; select cycles through 0..NUM_FIELDS-1; maximum 16.
- REPEAT_DELAY, 25000000, hold time before add auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, spacing between auto-repeat add pulses (AUTO_REPEAT_EN only).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- KEY  input  4  raw DE2 buttons, active-low, asynchronous. KEY[0]=add, KEY[1]=clr, KEY[2]=next field, KEY[3]=adjust toggle.
- add  output  1  one-cycle increment pulse for the selected field.
- clr  output  1  one-cycle clear-time pulse.
- adjust  output  1  level; 1 = adjust mode (time frozen, field editable).
- select  output  4  binary index of the field being adjusted.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - add=0, clr=0, adjust=0, select=0;
  - all synchroniser flops and debounced levels to 1 (released);
  - all debounce and repeat counters to 0.
- Reset mid-bounce or mid-hold discards that press. A key still held when rst deasserts gives no press event until it is released and pressed again.
- Per key, debouncing works as follows:
  - 2-flop synchroniser; its output is sync.
  - Counter clears whenever sync equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press event: debounced level 1->0. Release produces no event.
- Latency: KEY held low from edge N gives the press event in the cycle ending edge N+2+DEBOUNCE_CYCLES. The output pulse is registered, so it is high for the cycle after that.
- add:
  - One-cycle pulse on a KEY[0] press, only when adjust=1.
  - A press while adjust=0 is dropped, not queued.
- clr: one-cycle pulse on a KEY[1] press, in any mode.
- KEY[2] press:
  - adjust=1: select increments; select=NUM_FIELDS-1 wraps to 0.
  - adjust=0: ignored.
- KEY[3] press: toggles adjust.
  - Entering adjust forces select=0.
  - Leaving adjust holds select.
- Simultaneous KEY[2] and KEY[3] press events in the same cycle: the KEY[3] action wins.
  - Entering adjust: select=0.
  - Leaving adjust: select unchanged; the KEY[2] action is discarded.
- Simultaneous add and clr events: both pulses are asserted in the same cycle. The downstream time stage gives clr priority.
- A held key produces exactly one event, except add under AUTO_REPEAT_EN.
- select never exceeds NUM_FIELDS-1. Upper bits are 0 when NUM_FIELDS<=8.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - While adjust=1 and KEY[0] stays debounced-pressed, a hold counter runs.
  - First extra add pulse when the counter reaches REPEAT_DELAY cycles after the initial press event.
  - Further pulses every REPEAT_PERIOD cycles.
  - Release, adjust falling, or rst stops repetition and clears the counter.
- Undefined: no repeat counter is synthesised; exactly one add per press.

Decomposition:
- Shared package clock_pkg holds:
  - field index constants: FIELD_SEC=0, FIELD_MIN=1, FIELD_HOUR=2, FIELD_DAY=3, FIELD_MONTH=4, FIELD_YEAR_L=5, FIELD_YEAR_H=6;
  - SELECT_W=4;
  - key bit-position constants KEY_ADD=0, KEY_CLR=1, KEY_NEXT=2, KEY_ADJ=3.
- Sub-module key_debounce:
  - parameter DEBOUNCE_CYCLES;
  - ports CLOCK_50, rst, key_n, level, press;
  - press is a one-cycle pulse on debounced falling edge;
  - instantiated four times.
- key_control holds the mode/select logic and the optional repeat counter.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10.
1. Reset: hold rst for 3 cycles with KEY=4'hF -> add=0, clr=0, adjust=0, select=0 on the first edge with rst high and after.
2. Bounce: KEY[1] low for 5 cycles, high for 2, low held -> exactly one clr pulse, 10 cycles after the final low edge (2+8). Never two pulses. Release -> no pulse.
3. Mode gating: KEY[0] press with adjust=0 -> no add. KEY[3] press -> adjust=1, select=0. KEY[0] press -> one add pulse. KEY[2] pressed 7 times -> select 1,2,3,4,5,6,0.
4. Simultaneous: adjust=1, select=3, KEY[2] and KEY[3] pressed on the same edge -> adjust=0, select=3. Repeat from adjust=0 -> adjust=1, select=0.
5. Reset mid-operation: adjust=1, select=5, KEY[0] low for 4 cycles, then rst for 1 cycle -> adjust=0, select=0, no add while the key stays held. Release and re-press -> one add only after adjust is re-entered.
6. KEY_AUTO_REPEAT_EN: adjust=1, KEY[0] held 100 cycles after the press event -> add pulses at offsets 0, 40, 50, 60, 70, 80, 90. Without the macro -> only offset 0.
